encoder_priority: RTL and testbench
===================================

// Module: encoder_priority
// PURPOSE
// - Registered 8-to-3 priority encoder.
// - Reports the index of the highest-numbered asserted bit of request vector d.
// - A valid flag separates "bit 0 set" from "no bit set".
// - Used wherever a one-of-N arbitration or leading-one index is needed; output is registered for clean timing.
// PARAMETERS
// - WIDTH    8   input vector width; must be a power of two >= 2.
// - OUT_W    3   output index width; must equal clog2(WIDTH), so 3 for the default.
// PORTS
// - clk    in   1      system clock; all state updates on the rising edge.
// - rst    in   1      reset, asynchronous, active-high.
// - d      in   WIDTH  request vector; bit WIDTH-1 has highest priority.
// - y      out  OUT_W  encoded index of the highest set bit of d, registered.
// - valid  out  1      1 when the registered d had at least one bit set.
// BEHAVIOUR
// Clocking and reset
// - Single clock domain.
// - Reset is asynchronous and active-high on port rst; the clock port is clk.
// - While rst=1: y=0 and valid=0 immediately, without waiting for a clock edge.
// - On deassertion of rst, the first rising clk edge samples d normally.
// Encoding (combinational)
// - idx = largest i such that d[i]=1.
// - Scan runs from bit WIDTH-1 down to bit 0; the first 1 found wins.
// - Lower set bits are ignored when any higher bit is set.
// - any = |d.
// - d=0: idx=0, any=0.
// Output register
// - Each rising clk edge, when not in reset: y <= idx, valid <= any.
// - Latency is exactly 1 cycle; d sampled at edge N appears on y/valid after edge N.
// - No enable and no handshake; the register updates every cycle.
// - Outputs hold their value between edges; glitches on d between edges are invisible.
// Boundary conditions
// - d=0: y=0, valid=0.
// - d=1: y=0, valid=1.
// - d=8'hFF: y=7; the all-ones vector still resolves to the MSB.
// - A single-hot d gives y equal to the hot bit position.
// - X or Z on d is not defined; the bench drives only 0/1.
// - Reset mid-stream: outputs clear asynchronously; the next post-reset edge resumes normal encoding.
// - No internal state beyond the y/valid registers, so there are no states to recover.
// TESTING
// - Reset: rst=1 with d=8'hA5 -> y=0 and valid=0 immediately and throughout reset.
// - Exhaustive sweep: d=0..255, one value per cycle -> one cycle later y = index of MSB set;
//   for example d=8'h01->y=0, 8'h03->y=1, 8'h10->y=4, 8'h7F->y=6, 8'h80->y=7, 8'hFF->y=7;
//   valid=(d!=0).
// - Zero vs bit0: d=8'h00 -> y=0, valid=0; then d=8'h01 -> y=0, valid=1.
// - Priority masking: d=8'b1000_0001 -> y=7; d=8'b0010_0110 -> y=5; d=8'b0000_0110 -> y=2.
// - Latency check: change d between edges -> y changes only at the next rising clk edge, exactly 1 cycle later.
// - Async reset mid-sweep: assert rst between edges while y=6 -> y=0, valid=0 without a clock edge;
//   deassert, apply d=8'h40 -> y=6, valid=1 after the next edge.

Source files
------------

// File: rtl/encoder_priority.sv
// encoder_priority: registered priority encoder.
// Reports the index of the highest-numbered set bit of d, one cycle after
// sampling. valid separates "bit 0 set" (y=0, valid=1) from "nothing set"
// (y=0, valid=0). There is no state apart from the output register.
module encoder_priority #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [OUT_W-1:0] y,
    output logic             valid
);

    logic [OUT_W-1:0] idx;
    logic             any;

    // Ascending scan where the last hit wins, so the highest set bit takes priority.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                idx = OUT_W'(i);
            end
        end
    end

    assign any = |d;

    // Output register. Reset clears it immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            valid <= 1'b0;
        end else begin
            y     <= idx;
            valid <= any;
        end
    end

endmodule

// File: tb/tb_encoder_priority.sv
// tb_encoder_priority: directed checks plus a full sweep of all 256 inputs.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge, or between edges for the asynchronous reset checks.
module tb_encoder_priority;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [2:0] y;
    logic       valid;

    int total;
    int bad;

    encoder_priority #(.WIDTH(8), .OUT_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Index of the highest set bit, found by scanning down from the top.
    function automatic int msb_index(input logic [7:0] v);
        int k;
        k = 7;
        while (k > 0 && !v[k]) k--;
        return k;
    endfunction

    // Drive v on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        d = v;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] v;
        int         ey;
        int         ev;
    } vec_t;

    vec_t vecs[$];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        d     = 8'hA5;

        // Load a non-zero value first, so that clearing it proves the reset acts.
        @(posedge clk);
        #1;
        check("preload_y", int'(y), 7);
        check("preload_valid", int'(valid), 1);

        // Assert reset between edges. The outputs must clear with no clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_y", int'(y), 0);
        check("rst_async_valid", int'(valid), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_y", int'(y), 0);
        check("rst_hold_valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with expected values worked out by hand.
        vecs.push_back('{8'h00, 0, 0});
        vecs.push_back('{8'h01, 0, 1});
        vecs.push_back('{8'h03, 1, 1});
        vecs.push_back('{8'h10, 4, 1});
        vecs.push_back('{8'h7F, 6, 1});
        vecs.push_back('{8'h80, 7, 1});
        vecs.push_back('{8'hFF, 7, 1});
        vecs.push_back('{8'h81, 7, 1});
        vecs.push_back('{8'h26, 5, 1});
        vecs.push_back('{8'h06, 2, 1});
        vecs.push_back('{8'h08, 3, 1});
        vecs.push_back('{8'h00, 0, 0});
        foreach (vecs[i]) begin
            apply(vecs[i].v);
            check($sformatf("dir_y_%02h", vecs[i].v), int'(y), vecs[i].ey);
            check($sformatf("dir_valid_%02h", vecs[i].v), int'(valid), vecs[i].ev);
        end

        // Full sweep of every input value, checked against the reference scan.
        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
            check($sformatf("sweep_y_%02h", v), int'(y), msb_index(8'(v)));
            check($sformatf("sweep_valid_%02h", v), int'(valid), (v != 0) ? 1 : 0);
        end

        // Latency: changes to d between edges stay invisible until the next rising edge.
        apply(8'h02);
        check("lat_base_y", int'(y), 1);
        @(negedge clk);
        d = 8'h04;
        #1;
        check("lat_hold1_y", int'(y), 1);
        d = 8'h20;
        #1;
        check("lat_hold2_y", int'(y), 1);
        @(posedge clk);
        #1;
        check("lat_update_y", int'(y), 5);
        check("lat_update_valid", int'(valid), 1);

        // Reset in the middle of a stream while y=6, then resume after release.
        apply(8'h55);
        check("mid_pre_y", int'(y), 6);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        apply(8'h40);
        check("mid_resume_y", int'(y), 6);
        check("mid_resume_valid", int'(valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
